fifo_reader: RTL
================

# fifo_reader

Read-side adapter for the team's synchronous `fifo` block. It drives the FIFO's `pop`/`empty` interface, absorbs the one-cycle pop-to-data latency in a small internal skid buffer, and presents the words as a valid/ready stream to a downstream consumer such as instruction fetch or a bus master. It also provides a synchronous flush and a delivered-word counter for debug.

## Interface
- `WIDTH`, 32, data word width; must match the attached `fifo`.
- `BUF_DEPTH`, 3, skid buffer entries; minimum 2; 3 or more sustains 1 word/cycle.
- `clk_i`  in  1  clock; every register updates on the rising edge.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `fifo_empty_i`  in  1  `empty_o` of the attached `fifo`.
- `fifo_pop_o`  out  1  to `pop_i` of the attached `fifo`.
- `fifo_data_i`  in  WIDTH  `pop_data_o` of the attached `fifo`; valid the cycle after a pop.
- `flush_i`  in  1  discards buffered and in-flight words.
- `valid_o`  out  1  stream word available.
- `ready_i`  in  1  consumer accepts the word.
- `data_o`  out  WIDTH  stream word; defined only while `valid_o`=1.
- `level_o`  out  $clog2(BUF_DEPTH+1)  current skid buffer occupancy.
- `words_o`  out  32  count of completed stream handshakes.

## Operation
- State:
  - circular buffer `BUF_DEPTH`×`WIDTH` with rd/wr pointers and a `count`;
  - 1-bit `inflight` = registered `fifo_pop_o`;
  - 32-bit `words` counter.
- Pop rule, combinational:
  - `fifo_pop_o` = !`rst_i` && !`flush_i` && !`fifo_empty_i` && (`count` + `inflight`) < `BUF_DEPTH`.
  - `fifo_pop_o` never depends on `ready_i`.
- Capture: when `inflight`=1 and `flush_i`=0, `fifo_data_i` is written at the wr pointer, and the pointer advances modulo `BUF_DEPTH`.
- Output:
  - `valid_o` = (`count` != 0).
  - `data_o` = buffer at the rd pointer.
  - On `valid_o` && `ready_i`, the rd pointer advances modulo `BUF_DEPTH` and `words` increments, wrapping at 2^32.
- Simultaneous capture and handshake in one cycle: `count` is unchanged; the pointers move independently.
- Overflow cannot occur, because the pop rule reserves a slot for every in-flight word. Capturing into a full buffer is a design error; the bench asserts it never happens.
- Flush, when `flush_i`=1 in a cycle:
  - `count` goes to 0 and both pointers to 0;
  - an in-flight word arriving that cycle is dropped;
  - `inflight` is cleared next cycle, because `fifo_pop_o`=0;
  - a handshake in the flush cycle is still counted in `words`;
  - `valid_o` is 0 from the next cycle.
- Words still inside the `fifo` are not affected by flush.
- Order is preserved: words leave in exact FIFO pop order.

## Timing
- Reset values: `valid_o`=0, `data_o`=0 (all buffer entries zeroed), `level_o`=0, `words_o`=0, `inflight`=0. `fifo_pop_o`=0 while `rst_i`=1.
- Reset asserted mid-operation discards buffered and in-flight words, exactly like flush, and also zeroes `words_o`.
- Latency, with `fifo_empty_i` falling at cycle N and the buffer empty:
  - `fifo_pop_o`=1 in cycle N;
  - data is captured at the end of N+1;
  - `valid_o`=1 in cycle N+2.
- Throughput with `BUF_DEPTH`≥3, `ready_i` held at 1 and the FIFO non-empty: one word per cycle after the 2-cycle fill.
- Throughput with `BUF_DEPTH`=2 under the same conditions: 2 words per 3 cycles.
- Backpressure: while `ready_i`=0, `valid_o` and `data_o` stay stable until the handshake.
- `level_o` = `count`, registered.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with `fifo_empty_i`=0 → `fifo_pop_o`=0 and `valid_o`=0 throughout; `words_o`=0 afterwards.
- **Single word:** FIFO holds 0xDEADBEEF, `ready_i`=1 → pop in cycle 0; `valid_o`=1 with `data_o`=0xDEADBEEF in cycle 2 only; `words_o`=1.
- **Streaming:** 16 words 0..15, `BUF_DEPTH`=3, `ready_i`=1 → 16 consecutive handshakes from cycle 2 to cycle 17, in order; `words_o`=16.
- **Backpressure:** 8 words, `ready_i`=0 for 10 cycles then 1 → exactly 3 pops occur before stall; `level_o`=3; `data_o`=word0 stays stable; all 8 words then arrive in order.
- **Flush:** `level_o`=2 with one word in flight, pulse `flush_i` → `valid_o`=0 next cycle and the in-flight word is never emitted. The next word emitted is the FIFO's following entry.
- **Ready toggling:** 32 random words, random `ready_i` → the output sequence equals the input sequence, the overflow assertion never fires, and `words_o`=32.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: read-side adapter turning the fifo pop/empty port into a
// valid/ready stream through a small skid buffer, with flush and word count.
module fifo_reader #(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fifo_empty_i,
    output logic                           fifo_pop_o,
    input  logic [WIDTH-1:0]               fifo_data_i,
    input  logic                           flush_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] level_o,
    output logic [31:0]                    words_o
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LW = $clog2(BUF_DEPTH + 1);

    logic [WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_count;
    logic             r_inflight;
    logic [31:0]      r_words;

    logic [LW:0]      w_occ;
    logic             w_pop;
    logic             w_hs;
    logic             w_cap;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every in-flight word already owns a slot, so capture never overflows.
    assign w_occ = {1'b0, r_count} + {{LW{1'b0}}, r_inflight};
    assign w_pop = !rst_i && !flush_i && !fifo_empty_i
                   && (w_occ < (LW+1)'(BUF_DEPTH));
    assign w_hs  = (r_count != '0) && ready_i;
    assign w_cap = r_inflight && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_words    <= '0;
        end else begin
            r_inflight <= w_pop;
            if (w_hs) begin
                r_words <= r_words + 32'd1;
            end
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_cap) begin
                    r_buf[r_wr_ptr] <= fifo_data_i;
                    r_wr_ptr        <= next_ptr(r_wr_ptr);
                end
                if (w_hs) begin
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                end
                unique case ({w_cap, w_hs})
                    2'b10:   r_count <= r_count + LW'(1);
                    2'b01:   r_count <= r_count - LW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign fifo_pop_o = w_pop;
    assign valid_o    = (r_count != '0);
    assign data_o     = r_buf[r_rd_ptr];
    assign level_o    = r_count;
    assign words_o    = r_words;

endmodule
